// File: rtl/bp_pkg.sv
// bp_pkg: shared types for the branch-predictor update scheduler.
//   BP_PCSIZE     : default width of PC / target fields
//   bp_upd_t      : one resolved-branch update {pc, target, taken}
//   bp_sched_st_e : slot-arbitration FSM states
`timescale 1ns/1ps
package bp_pkg;

    localparam int BP_PCSIZE = 12;

    typedef struct packed {
        logic [BP_PCSIZE-1:0] pc;
        logic [BP_PCSIZE-1:0] target;
        logic                 taken;
    } bp_upd_t;

    typedef enum logic {
        S_NORM  = 1'b0,
        S_DRAIN = 1'b1
    } bp_sched_st_e;

endpackage

// File: rtl/bp_update_sched_fifo.sv
// bp_upd_fifo: DEPTH-entry circular FIFO of bp_upd_t updates.
// Macro BP_UPD_COALESCE_EN adds a tail peek and an in-place tail overwrite.
// Ports:
//   clk, rst_n  clock, async active-low reset (pointers and count only)
//   ovw         overwrite newest entry with wr_data (coalesce build only)
//   tail        newest entry (coalesce build only)
//   push        append wr_data
//   pop         drop head
//   wr_data     entry to append / overwrite with
//   head        oldest entry (undefined when empty)
//   count       occupancy 0..DEPTH
//   empty/full  occupancy flags
`timescale 1ns/1ps
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef BP_UPD_COALESCE_EN
    input  logic                   ovw,
    output bp_upd_t                tail,
`endif
    input  logic                   push,
    input  logic                   pop,
    input  bp_upd_t                wr_data,
    output bp_upd_t                head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    bp_upd_t       mem [DEPTH];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef BP_UPD_COALESCE_EN
    logic [PW-1:0] tail_ptr;
    assign tail_ptr = wr_ptr - PW'(1);
    assign tail     = mem[tail_ptr];

    always_ff @(posedge clk) begin
        if (push)     mem[wr_ptr]   <= wr_data;
        else if (ovw) mem[tail_ptr] <= wr_data;
    end
`else
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
`endif

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/bp_update_sched.sv
// bp_update_sched: serialises resolved-branch updates into the shared,
// single-ported predictor/BTB slot, arbitrating against fetch lookups.
// Lookups win by default; an update queue denied for MAX_STALL cycles, or
// a full queue, forces a drain phase where updates own the slot until empty.
// Optional macro BP_UPD_COALESCE_EN: a push matching the newest queued PC
// rewrites that entry in place instead of allocating a new one.
// PCSIZE must equal bp_pkg::BP_PCSIZE (queue entries use the package type).
// Ports:
//   clk, rst_n         clock, async active-low reset
//   ex_valid/ex_ready  resolved-branch handshake from execute
//   ex_pc/target/taken resolved branch contents
//   lk_req, lk_pc      fetch lookup request and PC
//   lk_gnt             lookup owns the slot this cycle
//   tbl_en/tbl_we      slot used / slot is an update write
//   tbl_addr           lookup PC when lk_gnt, else head PC
//   tbl_target/taken   head update contents
//   q_count            queue occupancy
//
// state   | meaning
// S_NORM  | lookups have priority; updates use idle slots
// S_DRAIN | updates own the slot until the queue empties
`timescale 1ns/1ps
module bp_update_sched
    import bp_pkg::*;
#(
    parameter int PCSIZE    = BP_PCSIZE,
    parameter int DEPTH     = 4,
    parameter int MAX_STALL = 8
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic [PCSIZE-1:0]      ex_pc,
    input  logic [PCSIZE-1:0]      ex_target,
    input  logic                   ex_taken,
    input  logic                   lk_req,
    input  logic [PCSIZE-1:0]      lk_pc,
    output logic                   lk_gnt,
    output logic                   tbl_en,
    output logic                   tbl_we,
    output logic [PCSIZE-1:0]      tbl_addr,
    output logic [PCSIZE-1:0]      tbl_target,
    output logic                   tbl_taken,
    output logic [$clog2(DEPTH):0] q_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(MAX_STALL + 1);

    bp_sched_st_e  state;
    logic [SW-1:0] stall_cnt;
    bp_upd_t       wr_data;
    bp_upd_t       head;
    logic          empty;
    logic          full;
    logic          upd_fire;
    logic          push_new;

    assign wr_data = '{pc: ex_pc, target: ex_target, taken: ex_taken};

    always_comb begin
        upd_fire = 1'b0;
        lk_gnt   = 1'b0;
        case (state)
            S_NORM: begin
                upd_fire = !empty && !lk_req;
                lk_gnt   = lk_req;
            end
            S_DRAIN: begin
                upd_fire = !empty;
                lk_gnt   = lk_req && empty;
            end
            default: ;
        endcase
    end

`ifdef BP_UPD_COALESCE_EN
    bp_upd_t tail;
    logic    tail_hit;
    logic    coal;

    // The newest entry cannot be rewritten in the cycle it is being written
    // to the table; such a push must allocate a fresh slot instead.
    assign tail_hit = !empty && (tail.pc == ex_pc) && !(upd_fire && q_count == CW'(1));
    assign ex_ready = !full || tail_hit;
    assign coal     = ex_valid && tail_hit;
    assign push_new = ex_valid && ex_ready && !coal;
`else
    assign ex_ready = !full;
    assign push_new = ex_valid && ex_ready;
`endif

    bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef BP_UPD_COALESCE_EN
        .ovw     (coal),
        .tail    (tail),
`endif
        .push    (push_new),
        .pop     (upd_fire),
        .wr_data (wr_data),
        .head    (head),
        .count   (q_count),
        .empty   (empty),
        .full    (full)
    );

    assign tbl_we     = upd_fire;
    assign tbl_en     = upd_fire || lk_gnt;
    assign tbl_addr   = lk_gnt ? lk_pc : head.pc;
    assign tbl_target = head.target;
    assign tbl_taken  = head.taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_NORM;
            stall_cnt <= '0;
        end else begin
            case (state)
                S_NORM: begin
                    if (upd_fire || empty)
                        stall_cnt <= '0;
                    else if (stall_cnt != SW'(MAX_STALL))
                        stall_cnt <= stall_cnt + SW'(1);
                    if ((stall_cnt == SW'(MAX_STALL - 1) && !empty && !upd_fire) || full)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Leave only when this pop empties the queue with nothing arriving.
                    if (upd_fire && q_count == CW'(1) && !push_new) begin
                        state     <= S_NORM;
                        stall_cnt <= '0;
                    end
                end
                default: state <= S_NORM;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_update_sched.sv
`timescale 1ns/1ps
module tb_bp_update_sched;
    localparam int PCSIZE    = 12;
    localparam int DEPTH     = 4;
    localparam int MAX_STALL = 8;
`ifdef BP_UPD_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ex_valid = 1'b0;
    logic              ex_ready;
    logic [PCSIZE-1:0] ex_pc = '0;
    logic [PCSIZE-1:0] ex_target = '0;
    logic              ex_taken = 1'b0;
    logic              lk_req = 1'b0;
    logic [PCSIZE-1:0] lk_pc = '0;
    logic              lk_gnt;
    logic              tbl_en;
    logic              tbl_we;
    logic [PCSIZE-1:0] tbl_addr;
    logic [PCSIZE-1:0] tbl_target;
    logic              tbl_taken;
    logic [2:0]        q_count;

    bp_update_sched #(.PCSIZE(PCSIZE), .DEPTH(DEPTH), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_taken(ex_taken),
        .lk_req(lk_req), .lk_pc(lk_pc), .lk_gnt(lk_gnt),
        .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_target(tbl_target), .tbl_taken(tbl_taken), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PCSIZE-1:0] pc;
        logic [PCSIZE-1:0] tgt;
        logic              tk;
    } upd_t;

    upd_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   streak = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard / reference: a plain list of pending updates in arrival order.
    always @(negedge clk) begin
        int   sz;
        bit   acc;
        bit   merge;
        upd_t e;
        upd_t n;
        if (!rst_n) begin
            exp_q.delete();
            streak = 0;
        end else begin
            sz = exp_q.size();
            chk("q_count", q_count, sz);
            if (COAL && sz > 0 && exp_q[sz-1].pc == ex_pc)
                chk("ex_ready", ex_ready, 1);
            else
                chk("ex_ready", ex_ready, (sz != DEPTH));
            chk("slot_excl", lk_gnt & tbl_we, 0);
            chk("tbl_en", tbl_en, tbl_we | lk_gnt);
            if (!lk_req) chk("gnt_no_req", lk_gnt, 0);
            if (lk_req && sz == 0) chk("gnt_idle", lk_gnt, 1);
            if (!lk_req && sz > 0) chk("write_idle_slot", tbl_we, 1);
            if (lk_gnt) chk("addr_lookup", tbl_addr, lk_pc);

            acc   = ex_valid && ex_ready;
            merge = COAL && acc && sz > 0 && exp_q[sz-1].pc == ex_pc && !(tbl_we && sz == 1);

            if (tbl_we) begin
                if (sz == 0) begin
                    chk("spurious_write", tbl_we, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_pc", tbl_addr, e.pc);
                    chk("wr_target", tbl_target, e.tgt);
                    chk("wr_taken", tbl_taken, e.tk);
                end
            end

            if (sz > 0 && !tbl_we) streak++;
            else streak = 0;
            chk("starvation", (streak > MAX_STALL), 0);

            if (acc) begin
                n.pc = ex_pc; n.tgt = ex_target; n.tk = ex_taken;
                if (merge) exp_q[exp_q.size()-1] = n;
                else exp_q.push_back(n);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PCSIZE-1:0] pc,
                         input logic [PCSIZE-1:0] tgt, input logic tk);
        ex_valid = v; ex_pc = pc; ex_target = tgt; ex_taken = tk;
    endtask

    task automatic idle_drain();
        int n;
        n = 0;
        ex_valid = 1'b0; lk_req = 1'b0; ex_pc = 12'hFFF;
        @(negedge clk);
        while (q_count != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_to_empty", q_count, 0);
        step();
    endtask

    initial begin
        int gnt_cnt;
        int w;
        bit got;

        // Reset values
        #2;
        chk("rst_q_count", q_count, 0);
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_lk_gnt", lk_gnt, 0);
        chk("rst_tbl_en", tbl_en, 0);
        chk("rst_tbl_we", tbl_we, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();

        // Idle fetch: write one cycle after push
        drive(1, 12'h010, 12'h040, 1);
        step();
        ex_valid = 1'b0;
        @(negedge clk);
        chk("idle_we", tbl_we, 1);
        chk("idle_addr", tbl_addr, 12'h010);
        chk("idle_target", tbl_target, 12'h040);
        chk("idle_taken", tbl_taken, 1);
        idle_drain();

        // Lookup priority then forced drain
        lk_req = 1'b1; lk_pc = 12'h7A5;
        drive(1, 12'h0A0, 12'h0B0, 0);
        step();
        ex_valid = 1'b0; ex_pc = 12'hFFF;
        gnt_cnt = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tbl_we) begin
                got = 1'b1;
                chk("drain_gnt", lk_gnt, 0);
                break;
            end
            if (lk_gnt) gnt_cnt++;
            step();
        end
        chk("drain_reached", got, 1);
        chk("gnt_cycles", gnt_cnt, MAX_STALL);
        step();
        @(negedge clk);
        chk("gnt_after_drain", lk_gnt, 1);
        chk("we_after_drain", tbl_we, 0);
        idle_drain();

        // Full queue under continuous lookups
        lk_req = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, 12'h100 + 12'(k), 12'h200 + 12'(k), k[0]);
            step();
        end
        ex_valid = 1'b0; ex_pc = 12'hFFF;
        @(negedge clk);
        chk("full_count", q_count, DEPTH);
        chk("full_ready", ex_ready, 0);
        step();
        w = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tbl_we) w++;
            else if (w > 0) break;
            step();
        end
        chk("full_drain_writes", w, DEPTH);
        idle_drain();

        // Wrap: back-to-back push/pop pairs
        lk_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive(1, 12'h300 + 12'(k * 3), 12'h400 + 12'(k), k[0]);
            step();
        end
        idle_drain();

        // Same-PC pushes while the slot is blocked
        lk_req = 1'b1;
        drive(1, 12'h020, 12'h050, 0);
        step();
        drive(1, 12'h020, 12'h060, 1);
        step();
        ex_valid = 1'b0; ex_pc = 12'hFFF;
        @(negedge clk);
        chk("coal_count", q_count, COAL ? 1 : 2);
        idle_drain();

        // Reset mid-drain with 3 entries left
        lk_req = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, 12'h500 + 12'(k), 12'h600 + 12'(k), 1);
            step();
        end
        ex_valid = 1'b0; ex_pc = 12'hFFF;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tbl_we) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chk("rst_drain_reached", got, 1);
        step();
        chk("pre_rst_count", q_count, 3);
        lk_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_q_count", q_count, 0);
        chk("midrst_tbl_en", tbl_en, 0);
        chk("midrst_ex_ready", ex_ready, 1);
        chk("midrst_tbl_we", tbl_we, 0);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step();

        // Randomised traffic
        for (int c = 0; c < 800; c++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            ex_valid  = 1'($urandom_range(0, 1));
            ex_pc     = (sel == 0) ? 12'h020 : (sel == 1) ? 12'h021 : 12'($urandom_range(0, 4095));
            ex_target = 12'($urandom_range(0, 4095));
            ex_taken  = 1'($urandom_range(0, 1));
            lk_req    = ($urandom_range(0, 9) < 7);
            lk_pc     = 12'($urandom_range(0, 4095));
            step();
        end
        idle_drain();
        chk("model_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
